// File: rtl/dds_ui_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : dds_ui_pkg                                                    |
// | Purpose  : Shared constants for the DDS front-panel controller: mode     |
// |            encoding, button indices, LED patterns and the 10^k step.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package dds_ui_pkg;

  // Panel operating modes; the encoding 2'd3 is never produced.
  typedef enum logic [1:0] {
    MODE_DDS = 2'd0,
    MODE_AM  = 2'd1,
    MODE_NUM = 2'd2
  } mode_t;

  // Bit positions inside the debounced button vector.
  localparam int BTN_MODE = 5;
  localparam int BTN_UP   = 4;
  localparam int BTN_POSP = 3;
  localparam int BTN_SEL  = 2;
  localparam int BTN_DOWN = 1;
  localparam int BTN_POSM = 0;

  // LED1 patterns.
  localparam logic [7:0] LED_WAVE0    = 8'b1100_0000;
  localparam logic [7:0] LED_WAVE1    = 8'b0011_0000;
  localparam logic [7:0] LED_WAVE2    = 8'b0000_1100;
  localparam logic [7:0] LED_WAVE3    = 8'b0000_0011;
  localparam logic [7:0] LED_UART_ON  = 8'b0000_1111;
  localparam logic [7:0] LED_UART_OFF = 8'b1111_0000;

  // Waveform index to its LED1 pattern.
  function automatic logic [7:0] wave_led(input logic [1:0] w);
    logic [7:0] r;
    case (w)
      2'd0:    r = LED_WAVE0;
      2'd1:    r = LED_WAVE1;
      2'd2:    r = LED_WAVE2;
      default: r = LED_WAVE3;
    endcase
    return r;
  endfunction

  // Frequency step for decade k (10^k); decades beyond 9 are not supported.
  function automatic int unsigned pow10(input int k);
    int unsigned r;
    r = 1;
    for (int i = 0; i < 10; i++) begin
      if (i < k) r = r * 10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dds_btn_evt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dds_btn_evt                                                   |
// | Purpose  : Rising-edge detector for one debounced button. With macro     |
// |            DDS_UI_AUTO_REPEAT_EN defined and REPEAT set, a held button   |
// |            also emits a pulse after HOLD_TICKS cycles and then every     |
// |            REPEAT_TICKS cycles until released.                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dds_btn_evt #(
  parameter int HOLD_TICKS   = 5000,
  parameter int REPEAT_TICKS = 1000,
  parameter bit REPEAT       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_evt
);

  logic r_last;
  logic w_edge;
  logic w_rep;

  assign w_edge = i_btn & ~r_last;
  // The event is combinational so the controller acts on the same edge
  // that first samples the button high.
  assign o_evt  = w_edge | w_rep;

  // Previous button level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= 1'b0;
    else        r_last <= i_btn;
  end

`ifdef DDS_UI_AUTO_REPEAT_EN
  if (REPEAT) begin : g_rep
    localparam int c_CW = $clog2(HOLD_TICKS + 1);
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_inc;
    logic            w_fire;

    assign w_inc  = r_cnt + 1'b1;
    // r_cnt holds the number of held samples since the press edge, so the
    // first repeat lands exactly HOLD_TICKS cycles after the edge.
    assign w_fire = i_btn & r_last & (w_inc == c_CW'(HOLD_TICKS));
    assign w_rep  = w_fire;

    // Hold counter: restarts on press or release, rewinds after each repeat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                r_cnt <= '0;
      else if (!i_btn || w_edge) r_cnt <= '0;
      else if (w_fire)           r_cnt <= c_CW'(HOLD_TICKS - REPEAT_TICKS);
      else                       r_cnt <= w_inc;
    end
  end else begin : g_norep
    assign w_rep = 1'b0;
  end
`else
  assign w_rep = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/dds_ui_ctl_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dds_ui_ctl_p                                                  |
// | Purpose  : Parametrised front-panel controller for the DDS design.       |
// |            Turns button/switch events into mode, waveform, saturating    |
// |            frequency control, digit editing and display data.            |
// |            Optional macro DDS_UI_AUTO_REPEAT_EN enables auto-repeat on   |
// |            held up/down buttons.                                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dds_ui_ctl_p
  import dds_ui_pkg::*;
#(
  parameter int                    NUM_DIGITS   = 8,
  parameter int                    DIGIT_RADIX  = 16,
  parameter int                    FREQ_W       = 12,
  parameter int                    FREQ_DIGITS  = 4,
  parameter int                    FREQ_MIN     = 1,
  parameter int                    FREQ_MAX     = 4095,
  parameter int                    FREQ_INIT    = 1,
  parameter logic [4*NUM_DIGITS-1:0] NUM_INIT   = 32'h68011033,
  parameter int                    HOLD_TICKS   = 5000,
  parameter int                    REPEAT_TICKS = 1000
) (
  input  logic                    clk_10khz,
  input  logic                    rst_n,
  input  logic [5:0]              btn_value,
  input  logic [7:0]              switch,
  input  logic [7:0]              to_DAC,
  input  logic [4*NUM_DIGITS-1:0] freq_data_pool,
  input  logic [4*NUM_DIGITS-1:0] freq_ctl_data_pool,
  input  logic [4*NUM_DIGITS-1:0] uart_recv_data,
  output logic [7:0]              LED0,
  output logic [7:0]              LED1,
  output logic [1:0]              wave_select,
  output logic                    dac_mode,
  output logic                    uart_mode,
  output logic [FREQ_W-1:0]       freq_ctl,
  output logic [1:0]              global_mode,
  output logic [4*NUM_DIGITS-1:0] data
);

  localparam int c_DW    = 4 * NUM_DIGITS;
  localparam int c_FPW   = (FREQ_DIGITS > 1) ? $clog2(FREQ_DIGITS) : 1;
  localparam int c_NPW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_HALF  = 4 * (NUM_DIGITS / 2);
  localparam int c_PAD_D = NUM_DIGITS - NUM_DIGITS / 2;

  localparam logic [c_FPW-1:0]  c_FPOS_LAST = c_FPW'(FREQ_DIGITS - 1);
  localparam logic [c_NPW-1:0]  c_NPOS_LAST = c_NPW'(NUM_DIGITS - 1);
  localparam logic [FREQ_W:0]   c_FMAX      = (FREQ_W + 1)'(FREQ_MAX);
  localparam logic [FREQ_W:0]   c_FMIN      = (FREQ_W + 1)'(FREQ_MIN);
  localparam logic [FREQ_W-1:0] c_FMAX_W    = FREQ_W'(FREQ_MAX);
  localparam logic [FREQ_W-1:0] c_FMIN_W    = FREQ_W'(FREQ_MIN);

  // ---------------------------------------------------------------- events
  logic [5:0] w_evt;

  for (genvar gi = 0; gi < 6; gi++) begin : g_btn
    dds_btn_evt #(
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT      ((gi == BTN_UP) || (gi == BTN_DOWN))
    ) u_evt (
      .clk  (clk_10khz),
      .rst_n(rst_n),
      .i_btn(btn_value[gi]),
      .o_evt(w_evt[gi])
    );
  end

  // ------------------------------------------------------------------ state
  mode_t             r_mode, w_mode_nxt;
  logic [1:0]        r_wave, w_wave_nxt;
  logic              r_dac_mode, w_dac_nxt;
  logic              r_uart_mode, w_umode_nxt;
  logic [FREQ_W-1:0] r_freq, w_freq_nxt;
  logic [c_FPW-1:0]  r_fpos, w_fpos_nxt;
  logic [c_NPW-1:0]  r_npos, w_npos_nxt;
  logic [c_DW-1:0]   r_pool, w_pool_nxt;
  logic              r_uart_disp, w_udisp_nxt;
  logic [c_DW-1:0]   r_uart_last;
  logic [7:0]        r_led0, w_led0_nxt;
  logic [7:0]        r_led1, w_led1_nxt;
  logic [c_DW-1:0]   r_data, w_data_nxt;

  // Saturating frequency arithmetic, one guard bit above FREQ_W.
  logic [FREQ_W:0]   w_step;
  logic [FREQ_W:0]   w_sum;
  logic [FREQ_W:0]   w_diff;
  logic [FREQ_W-1:0] w_freq_up;
  logic [FREQ_W-1:0] w_freq_dn;

  assign w_step    = (FREQ_W + 1)'(pow10(int'(r_fpos)));
  assign w_sum     = {1'b0, r_freq} + w_step;
  assign w_diff    = {1'b0, r_freq} - w_step;
  assign w_freq_up = (w_sum > c_FMAX) ? c_FMAX_W : w_sum[FREQ_W-1:0];
  // A set guard bit means the subtraction borrowed below zero.
  assign w_freq_dn = (w_diff[FREQ_W] || (w_diff < c_FMIN)) ? c_FMIN_W
                                                           : w_diff[FREQ_W-1:0];

  // Selected digit of the edit pool and its up/down neighbours.
  logic [3:0]      w_dig;
  logic [3:0]      w_dig_up;
  logic [3:0]      w_dig_dn;
  logic [c_DW-1:0] w_am_data;

  assign w_dig     = r_pool[{r_npos, 2'b00} +: 4];
  assign w_am_data = {{c_PAD_D{4'hA}}, freq_data_pool[c_DW-1 -: c_HALF]};

  // Digit increment/decrement in the configured radix.
  always_comb begin
    w_dig_up = w_dig + 4'd1;
    w_dig_dn = w_dig - 4'd1;
    if (DIGIT_RADIX == 10) begin
      w_dig_up = (w_dig >= 4'd9) ? 4'd0 : w_dig + 4'd1;
      w_dig_dn = ((w_dig == 4'd0) || (w_dig > 4'd9)) ? 4'd9 : w_dig - 4'd1;
    end
  end

  // Mode state register.
  always_ff @(posedge clk_10khz or negedge rst_n) begin
    if (!rst_n) r_mode <= MODE_DDS;
    else        r_mode <= w_mode_nxt;
  end

  // Mode sequencing DDS -> AM -> NUM -> DDS; stray encodings return to DDS.
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      MODE_DDS: if (w_evt[BTN_MODE]) w_mode_nxt = MODE_AM;
      MODE_AM:  if (w_evt[BTN_MODE]) w_mode_nxt = MODE_NUM;
      MODE_NUM: if (w_evt[BTN_MODE]) w_mode_nxt = MODE_DDS;
      default:  w_mode_nxt = MODE_DDS;
    endcase
  end

  // Per-mode actions and next output values; the current mode acts even on
  // the cycle its mode button is pressed.
  always_comb begin
    w_wave_nxt  = r_wave;
    w_dac_nxt   = r_dac_mode;
    w_umode_nxt = r_uart_mode;
    w_freq_nxt  = r_freq;
    w_fpos_nxt  = r_fpos;
    w_npos_nxt  = r_npos;
    w_pool_nxt  = r_pool;
    w_udisp_nxt = r_uart_disp;
    w_led0_nxt  = r_led0;
    w_led1_nxt  = r_led1;
    w_data_nxt  = r_data;
    case (r_mode)
      MODE_DDS: begin
        w_dac_nxt = 1'b1;
        if (w_evt[BTN_SEL]) w_wave_nxt = r_wave + 2'd1;
        w_led1_nxt = wave_led(w_wave_nxt);
        if (switch == 8'd0) begin
          w_led0_nxt = to_DAC;
          w_data_nxt = freq_data_pool;
        end else begin
          w_data_nxt = freq_ctl_data_pool;
          if (w_evt[BTN_POSP])
            w_fpos_nxt = (r_fpos == c_FPOS_LAST) ? '0 : r_fpos + 1'b1;
          else if (w_evt[BTN_POSM])
            w_fpos_nxt = (r_fpos == '0) ? c_FPOS_LAST : r_fpos - 1'b1;
          if (w_evt[BTN_UP])        w_freq_nxt = w_freq_up;
          else if (w_evt[BTN_DOWN]) w_freq_nxt = w_freq_dn;
          w_led0_nxt = 8'd1 << w_fpos_nxt;
        end
      end
      MODE_AM: begin
        w_dac_nxt  = 1'b0;
        w_led0_nxt = 8'd0;
        w_led1_nxt = to_DAC;
        w_data_nxt = w_am_data;
      end
      MODE_NUM: begin
        w_dac_nxt = 1'b0;
        if (w_evt[BTN_SEL]) w_umode_nxt = ~r_uart_mode;
        w_led1_nxt = w_umode_nxt ? LED_UART_ON : LED_UART_OFF;
        if (uart_recv_data != r_uart_last) w_udisp_nxt = 1'b1;
        // Local editing takes the display back from the UART word.
        if (w_evt[BTN_POSP] | w_evt[BTN_POSM] | w_evt[BTN_UP] | w_evt[BTN_DOWN])
          w_udisp_nxt = 1'b0;
        if (w_evt[BTN_POSP])
          w_npos_nxt = (r_npos == c_NPOS_LAST) ? '0 : r_npos + 1'b1;
        else if (w_evt[BTN_POSM])
          w_npos_nxt = (r_npos == '0) ? c_NPOS_LAST : r_npos - 1'b1;
        if (w_evt[BTN_UP])        w_pool_nxt[{r_npos, 2'b00} +: 4] = w_dig_up;
        else if (w_evt[BTN_DOWN]) w_pool_nxt[{r_npos, 2'b00} +: 4] = w_dig_dn;
        w_led0_nxt = w_udisp_nxt ? r_led0 : (8'd1 << w_npos_nxt);
        w_data_nxt = w_udisp_nxt ? uart_recv_data : w_pool_nxt;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_10khz or negedge rst_n) begin
    if (!rst_n) begin
      r_wave      <= 2'd0;
      r_dac_mode  <= 1'b1;
      r_uart_mode <= 1'b1;
      r_freq      <= FREQ_W'(FREQ_INIT);
      r_fpos      <= '0;
      r_npos      <= '0;
      r_pool      <= NUM_INIT;
      r_uart_disp <= 1'b0;
      r_uart_last <= '0;
      r_led0      <= 8'd0;
      r_led1      <= 8'd0;
      r_data      <= '0;
    end else begin
      r_wave      <= w_wave_nxt;
      r_dac_mode  <= w_dac_nxt;
      r_uart_mode <= w_umode_nxt;
      r_freq      <= w_freq_nxt;
      r_fpos      <= w_fpos_nxt;
      r_npos      <= w_npos_nxt;
      r_pool      <= w_pool_nxt;
      r_uart_disp <= w_udisp_nxt;
      r_uart_last <= uart_recv_data;
      r_led0      <= w_led0_nxt;
      r_led1      <= w_led1_nxt;
      r_data      <= w_data_nxt;
    end
  end

  assign LED0        = r_led0;
  assign LED1        = r_led1;
  assign wave_select = r_wave;
  assign dac_mode    = r_dac_mode;
  assign uart_mode   = r_uart_mode;
  assign freq_ctl    = r_freq;
  assign global_mode = r_mode;
  assign data        = r_data;

endmodule
`default_nettype wire

// File: tb/tb_dds_ui_ctl_p.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dds_ui_ctl_p                                               |
// | Purpose  : Directed self-checking bench for dds_ui_ctl_p. One instance   |
// |            uses hex digit edit, a second uses BCD; both share stimulus.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dds_ui_ctl_p;

  localparam logic [5:0] B_MODE = 6'b100000;
  localparam logic [5:0] B_UP   = 6'b010000;
  localparam logic [5:0] B_POSP = 6'b001000;
  localparam logic [5:0] B_SEL  = 6'b000100;
  localparam logic [5:0] B_DOWN = 6'b000010;
  localparam logic [5:0] B_POSM = 6'b000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  btn = 6'd0;
  logic [7:0]  sw = 8'd0;
  logic [7:0]  dac_in = 8'd0;
  logic [31:0] fdp = 32'd0;
  logic [31:0] fcdp = 32'd0;
  logic [31:0] uart = 32'd0;

  logic [7:0]  h_led0, h_led1, b_led0, b_led1;
  logic [1:0]  h_wave, b_wave, h_gmode, b_gmode;
  logic        h_dac, b_dac, h_umode, b_umode;
  logic [11:0] h_freq, b_freq;
  logic [31:0] h_data, b_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dds_ui_ctl_p u_dut_hex (
    .clk_10khz(clk), .rst_n(rst_n), .btn_value(btn), .switch(sw), .to_DAC(dac_in),
    .freq_data_pool(fdp), .freq_ctl_data_pool(fcdp), .uart_recv_data(uart),
    .LED0(h_led0), .LED1(h_led1), .wave_select(h_wave), .dac_mode(h_dac),
    .uart_mode(h_umode), .freq_ctl(h_freq), .global_mode(h_gmode), .data(h_data)
  );

  dds_ui_ctl_p #(.DIGIT_RADIX(10)) u_dut_bcd (
    .clk_10khz(clk), .rst_n(rst_n), .btn_value(btn), .switch(sw), .to_DAC(dac_in),
    .freq_data_pool(fdp), .freq_ctl_data_pool(fcdp), .uart_recv_data(uart),
    .LED0(b_led0), .LED1(b_led1), .wave_select(b_wave), .dac_mode(b_dac),
    .uart_mode(b_umode), .freq_ctl(b_freq), .global_mode(b_gmode), .data(b_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [5:0] m);
    btn = m;
    tick();
    btn = 6'd0;
    tick();
  endtask

  task automatic test_reset();
    fdp = 32'h12345678; fcdp = 32'h0BADF00D; dac_in = 8'h5A;
    tick(); tick();
    checks++; if (h_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=%h", h_data, 32'h0); end
    checks++; if (h_led0 !== 8'h0 || h_led1 !== 8'h0) begin errors++; $display("FAIL rst_leds got=%h/%h exp=00/00", h_led0, h_led1); end
    checks++; if (h_dac !== 1'b1 || h_umode !== 1'b1) begin errors++; $display("FAIL rst_flags got dac=%b umode=%b exp=1/1", h_dac, h_umode); end
    checks++; if (h_freq !== 12'd1 || h_gmode !== 2'd0 || h_wave !== 2'd0) begin errors++; $display("FAIL rst_state got freq=%0d mode=%0d wave=%0d exp=1/0/0", h_freq, h_gmode, h_wave); end
    rst_n = 1'b1;
    tick();
    checks++; if (h_data !== 32'h12345678 || h_led0 !== 8'h5A || h_led1 !== 8'hC0) begin errors++; $display("FAIL dds_idle got data=%h led0=%h led1=%h exp=12345678/5a/c0", h_data, h_led0, h_led1); end
  endtask

  task automatic test_mode_cycle();
    press(B_MODE);
    checks++; if (h_gmode !== 2'd1 || h_dac !== 1'b0) begin errors++; $display("FAIL mode1 got mode=%0d dac=%b exp=1/0", h_gmode, h_dac); end
    checks++; if (h_data !== 32'hAAAA1234 || h_led1 !== 8'h5A || h_led0 !== 8'h00) begin errors++; $display("FAIL am_out got data=%h led1=%h led0=%h exp=aaaa1234/5a/00", h_data, h_led1, h_led0); end
    press(B_MODE);
    checks++; if (h_gmode !== 2'd2 || h_dac !== 1'b0) begin errors++; $display("FAIL mode2 got mode=%0d dac=%b exp=2/0", h_gmode, h_dac); end
    checks++; if (h_data !== 32'h68011033 || h_led1 !== 8'h0F || h_led0 !== 8'h01) begin errors++; $display("FAIL num_out got data=%h led1=%h led0=%h exp=68011033/0f/01", h_data, h_led1, h_led0); end
    press(B_MODE);
    checks++; if (h_gmode !== 2'd0 || h_dac !== 1'b1) begin errors++; $display("FAIL mode0 got mode=%0d dac=%b exp=0/1", h_gmode, h_dac); end
    press(B_MODE);
    checks++; if (h_gmode !== 2'd1 || h_dac !== 1'b0) begin errors++; $display("FAIL mode1b got mode=%0d dac=%b exp=1/0", h_gmode, h_dac); end
    press(B_MODE);
    press(B_MODE);
  endtask

  task automatic test_wave();
    press(B_SEL);
    checks++; if (h_wave !== 2'd1 || h_led1 !== 8'h30) begin errors++; $display("FAIL wave1 got wave=%0d led1=%h exp=1/30", h_wave, h_led1); end
    press(B_SEL);
    press(B_SEL);
    checks++; if (h_wave !== 2'd3 || h_led1 !== 8'h03) begin errors++; $display("FAIL wave3 got wave=%0d led1=%h exp=3/03", h_wave, h_led1); end
    press(B_SEL);
    checks++; if (h_wave !== 2'd0 || h_led1 !== 8'hC0) begin errors++; $display("FAIL wave_wrap got wave=%0d led1=%h exp=0/c0", h_wave, h_led1); end
  endtask

  task automatic test_freq_sat();
    sw = 8'h01;
    press(B_POSM);
    checks++; if (h_led0 !== 8'h08 || h_data !== 32'h0BADF00D) begin errors++; $display("FAIL fpos_wrap got led0=%h data=%h exp=08/0badf00d", h_led0, h_data); end
    repeat (4) press(B_UP);
    checks++; if (h_freq !== 12'd4001) begin errors++; $display("FAIL freq_up got=%0d exp=4001", h_freq); end
    press(B_UP);
    checks++; if (h_freq !== 12'd4095) begin errors++; $display("FAIL freq_max got=%0d exp=4095", h_freq); end
    repeat (4) press(B_DOWN);
    checks++; if (h_freq !== 12'd95) begin errors++; $display("FAIL freq_down got=%0d exp=95", h_freq); end
    press(B_DOWN);
    checks++; if (h_freq !== 12'd1) begin errors++; $display("FAIL freq_underflow got=%0d exp=1", h_freq); end
    press(B_POSP);
    repeat (4) press(B_UP);
    press(B_POSP);
    checks++; if (h_freq !== 12'd5 || h_led0 !== 8'h02) begin errors++; $display("FAIL freq_pos1 got freq=%0d led0=%h exp=5/02", h_freq, h_led0); end
    press(B_DOWN);
    checks++; if (h_freq !== 12'd1) begin errors++; $display("FAIL freq_min got=%0d exp=1", h_freq); end
    press(B_POSP | B_POSM);
    press(B_UP | B_DOWN);
    checks++; if (h_freq !== 12'd101 || h_led0 !== 8'h04) begin errors++; $display("FAIL freq_prio got freq=%0d led0=%h exp=101/04", h_freq, h_led0); end
    press(B_POSM);
    press(B_DOWN);
    checks++; if (h_freq !== 12'd91) begin errors++; $display("FAIL freq_sub got=%0d exp=91", h_freq); end
    sw = 8'h00;
    tick();
    checks++; if (h_led0 !== 8'h5A || h_data !== 32'h12345678) begin errors++; $display("FAIL sw_off got led0=%h data=%h exp=5a/12345678", h_led0, h_data); end
  endtask

  task automatic test_num_edit();
    press(B_MODE);
    press(B_MODE);
    press(B_UP);
    checks++; if (h_data !== 32'h68011034 || b_data !== 32'h68011034) begin errors++; $display("FAIL dig_up got hex=%h bcd=%h exp=68011034", h_data, b_data); end
    press(B_POSM);
    press(B_POSM);
    checks++; if (h_led0 !== 8'h40) begin errors++; $display("FAIL npos_wrap got led0=%h exp=40", h_led0); end
    press(B_UP);
    press(B_UP);
    checks++; if (h_data !== 32'h6A011034) begin errors++; $display("FAIL hex_up got=%h exp=6a011034", h_data); end
    checks++; if (b_data !== 32'h60011034) begin errors++; $display("FAIL bcd_wrap_up got=%h exp=60011034", b_data); end
    press(B_DOWN);
    checks++; if (h_data !== 32'h69011034 || b_data !== 32'h69011034) begin errors++; $display("FAIL dig_down got hex=%h bcd=%h exp=69011034", h_data, b_data); end
    press(B_POSM);
    press(B_DOWN);
    checks++; if (h_data !== 32'h69F11034) begin errors++; $display("FAIL hex_wrap_dn got=%h exp=69f11034", h_data); end
    checks++; if (b_data !== 32'h69911034) begin errors++; $display("FAIL bcd_wrap_dn got=%h exp=69911034", b_data); end
  endtask

  task automatic test_uart();
    uart = 32'hDEADBEEF;
    tick();
    checks++; if (h_data !== 32'hDEADBEEF || h_led0 !== 8'h20) begin errors++; $display("FAIL uart_show got data=%h led0=%h exp=deadbeef/20", h_data, h_led0); end
    tick();
    checks++; if (h_data !== 32'hDEADBEEF || h_led0 !== 8'h20) begin errors++; $display("FAIL uart_hold got data=%h led0=%h exp=deadbeef/20", h_data, h_led0); end
    uart = 32'hCAFEF00D;
    btn = B_POSP;
    tick();
    checks++; if (h_data !== 32'h69F11034 || b_data !== 32'h69911034 || h_led0 !== 8'h40) begin errors++; $display("FAIL uart_clear got hex=%h bcd=%h led0=%h exp=69f11034/69911034/40", h_data, b_data, h_led0); end
    btn = 6'd0;
    tick();
    press(B_SEL);
    checks++; if (h_umode !== 1'b0 || h_led1 !== 8'hF0) begin errors++; $display("FAIL uart_toggle got umode=%b led1=%h exp=0/f0", h_umode, h_led1); end
  endtask

  task automatic test_reset_mid_hold();
    btn = B_UP;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (h_data !== 32'h0 || h_freq !== 12'd1 || h_gmode !== 2'd0) begin errors++; $display("FAIL rst_async got data=%h freq=%0d mode=%0d exp=0/1/0", h_data, h_freq, h_gmode); end
    tick();
    checks++; if (h_data !== 32'h0) begin errors++; $display("FAIL rst_hold got data=%h exp=0", h_data); end
    btn = 6'd0;
    rst_n = 1'b1;
    tick();
    checks++; if (h_umode !== 1'b1 || h_gmode !== 2'd0) begin errors++; $display("FAIL rst_release got umode=%b mode=%0d exp=1/0", h_umode, h_gmode); end
    press(B_MODE);
    press(B_MODE);
    checks++; if (h_data !== 32'h68011033 || b_data !== 32'h68011033 || h_led0 !== 8'h01) begin errors++; $display("FAIL pool_restore got hex=%h bcd=%h led0=%h exp=68011033/01", h_data, b_data, h_led0); end
  endtask

  task automatic test_hold_repeat();
    press(B_MODE);
    sw = 8'h01;
    tick();
    btn = B_UP;
    tick();
    checks++; if (h_freq !== 12'd2) begin errors++; $display("FAIL hold_edge got=%0d exp=2", h_freq); end
`ifdef DDS_UI_AUTO_REPEAT_EN
    repeat (4999) tick();
    checks++; if (h_freq !== 12'd2) begin errors++; $display("FAIL rep_early got=%0d exp=2", h_freq); end
    tick();
    checks++; if (h_freq !== 12'd3) begin errors++; $display("FAIL rep_first got=%0d exp=3", h_freq); end
    repeat (999) tick();
    checks++; if (h_freq !== 12'd3) begin errors++; $display("FAIL rep_gap got=%0d exp=3", h_freq); end
    tick();
    checks++; if (h_freq !== 12'd4) begin errors++; $display("FAIL rep_second got=%0d exp=4", h_freq); end
    repeat (999) tick();
    btn = 6'd0;
    tick();
    checks++; if (h_freq !== 12'd4) begin errors++; $display("FAIL rep_total got=%0d exp=4", h_freq); end
`else
    repeat (100) tick();
    btn = 6'd0;
    tick();
    checks++; if (h_freq !== 12'd2) begin errors++; $display("FAIL no_repeat got=%0d exp=2", h_freq); end
`endif
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_wave();
    test_freq_sat();
    test_num_edit();
    test_uart();
    test_reset_mid_hold();
    test_hold_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
